// File: rtl/memory_io_responder.sv
// Target end of the memory_io protocol: word storage with byte-lane writes/read masks and
// a fixed-latency response pipeline that freezes while a response waits for req_ack.
module memory_io_responder #(
    parameter int DEPTH_WORDS = 16384,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    // req = {addr[31:0], data[31:0], do_read[3:0], do_write[3:0], valid}
    input  logic [72:0] req,
    // rsp = {addr[31:0], data[31:0], valid, ready}
    output logic [65:0] rsp,
    input  logic        req_ack
);
    localparam int AW = $clog2(DEPTH_WORDS);

    generate
        if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
            $error("memory_io_responder: LATENCY must be in 1..4");
        end
    endgenerate

    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_do_read;
    logic [3:0]  req_do_write;
    logic        req_valid;

    assign {req_addr, req_data, req_do_read, req_do_write, req_valid} = req;

    logic [31:0]   mem [DEPTH_WORDS];
    logic          slot_valid [LATENCY];
    logic [31:0]   slot_addr  [LATENCY];
    logic [31:0]   slot_data  [LATENCY];

    logic [AW-1:0] index;
    logic [31:0]   read_word;
    logic [31:0]   read_masked;
    logic          out_valid;
    logic          stall;
    logic          ready;
    logic          accept;

    // Handshake: a request transfers on a rising edge where req.valid & rsp.ready (and reset
    // is released); a response is consumed on the edge where rsp.valid & req_ack. While a
    // response waits, ready drops so nothing new enters and the whole pipeline holds.
    assign index     = req_addr[AW+1:2];
    assign read_word = mem[index];
    assign out_valid = slot_valid[LATENCY-1];
    assign stall     = out_valid & ~req_ack;
    assign ready     = ~stall;
    assign accept    = req_valid & ready & reset;

    always_comb begin
        read_masked = '0;
        for (int i = 0; i < 4; i++) begin
            if (req_do_read[i]) read_masked[8*i +: 8] = read_word[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                slot_valid[i] <= 1'b0;
                slot_addr[i]  <= '0;
                slot_data[i]  <= '0;
            end
        end else if (!stall) begin
            slot_valid[0] <= accept & (|req_do_read);
            slot_addr[0]  <= accept ? req_addr : '0;
            slot_data[0]  <= accept ? read_masked : '0;
            for (int i = 1; i < LATENCY; i++) begin
                slot_valid[i] <= slot_valid[i-1];
                slot_addr[i]  <= slot_addr[i-1];
                slot_data[i]  <= slot_data[i-1];
            end
        end
    end

    // Storage is deliberately not reset; the read above samples the word before this write lands.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < 4; i++) begin
                if (req_do_write[i]) mem[index][8*i +: 8] <= req_data[8*i +: 8];
            end
        end
    end

    assign rsp = {out_valid ? slot_addr[LATENCY-1] : 32'h0,
                  out_valid ? slot_data[LATENCY-1] : 32'h0,
                  out_valid, ready};
endmodule

// File: doc/memory_io_responder.md
Name: memory_io_responder

Overview:
- Target end of the memory_io protocol: accepts memory_io_req from a pipelined core (instruction or data port) and returns memory_io_rsp after a fixed, parameterised latency.
- Word-organised synchronous storage with byte-lane writes and byte-lane read masking.
- Response pipeline with stall on missing acknowledge, so the core's IF1→DEC (2-cycle) and MEM1→MEM2 request/response timing is met exactly.
- One instance per core port; serves as the bench and FPGA memory for the 7-stage core.

Parameters:
DEPTH_WORDS, 16384, number of 32-bit words; power of two; index width AW = log2(DEPTH_WORDS)
LATENCY, 2, cycles from request acceptance to rsp.valid; legal range 1..4

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
req  input  memory_io_req  request: addr[31:0], data[31:0], do_read[3:0], do_write[3:0], valid
rsp  output  memory_io_rsp  response: addr[31:0], data[31:0], valid, ready
req_ack  input  1  initiator acknowledges the response currently presented on rsp

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low.
- Reset asserted (reset=0), asynchronous: rsp.valid=0, rsp.data=0, rsp.addr=0, rsp.ready=1, all pipeline slots invalid. Storage contents are not reset. Pending responses are discarded when reset is asserted mid-operation, with no write or response issued afterwards.
- Word index = req.addr[AW+1:2]. Bits above AW+1 are ignored (aliasing). addr[1:0] is ignored; lane selection comes only from the do_* masks.
- Accept = req.valid & rsp.ready. Requests presented while ready=0 are neither performed nor queued; the initiator must hold them.
- Write: on an accepted edge, byte lane i of word[index] is replaced by req.data[8i+7:8i] for every do_write[i]=1. The write is visible to any request accepted on the next cycle or later.
- Read: on acceptance, the word is sampled before any same-cycle write, so a combined read+write returns the old data. The result enters slot 0 of a LATENCY-deep shift pipeline carrying {valid_read, addr, data}. valid_read = |do_read.
- Read data masking: byte lane i = stored byte if do_read[i], else 8'h00.
- Write-only and null requests (do_read=0) occupy a slot with valid_read=0 and never raise rsp.valid.
- Output stage = last pipeline slot. rsp.valid = valid_read of that slot; rsp.addr and rsp.data come from that slot and are 0 when it is invalid.
- Timing: a request accepted at edge N appears on rsp during the cycle after edge N+LATENCY-1, i.e. LATENCY=2 gives data one full cycle after the request cycle.
- Stall = rsp.valid & ~req_ack.
  - While stalled, the entire pipeline freezes, rsp holds stable (valid, addr, data unchanged), and rsp.ready=0 combinationally.
  - The stall releases on the edge where req_ack=1; the pipeline advances and ready returns to 1 in the same cycle req_ack is seen.
- Back-to-back: with req_ack held 1, one request is accepted per cycle and throughput is 1/cycle with no bubbles.
- Ordering: responses are returned strictly in acceptance order.
- Simultaneous accept and stall cannot occur, because ready=0 whenever stalled.
- Unsupported LATENCY values (0 or >4) are a static elaboration error.

Test Plan:
- Reset: hold reset=0 for 3 cycles with req.valid=1 -> rsp.valid=0, rsp.data=0, rsp.ready=1. After release, first read of any address completes LATENCY cycles later.
- Write then read: write addr 0x100, data 0xDEADBEEF, do_write=4'b1111; next cycle read 0x100 with do_read=4'b1111 -> rsp.valid=1 two cycles later with data 0xDEADBEEF, addr 0x100.
- Byte lanes: write 0x11223344 full word, then write 0x000000AA with do_write=4'b0001, then read with do_read=4'b0011 -> data 0x000033AA.
- Read+write same request: location holds 0x5; request with do_read=4'hF, do_write=4'hF, data 0x9 -> response 0x5; subsequent read -> 0x9.
- Back-pressure: stream reads of 0x0, 0x4, 0x8 with req_ack=0 when the first response appears -> rsp holds 0x0 data, ready=0, no further accepts. req_ack=1 for 3 cycles -> responses for 0x0, 0x4, 0x8 in order.
- Mid-op reset and aliasing: issue 2 reads, assert reset one cycle later -> no rsp.valid after release. Write to addr (DEPTH_WORDS*4)+0x8, read 0x8 -> same data returned.
